// File: rtl/fht_addr_sched.sv
// Address scheduler for an in-place radix-2 fast Hartley transform.
// Walks L stages of N/2 butterflies, producing read pairs, twiddle index,
// and the matching write pairs/bank strobes PIPE_LAT cycles later.
module fht_addr_sched #(
    parameter  int LOG_N_MAX = 10,
    parameter  int PIPE_LAT  = 4,
    localparam int LN_BIT    = $clog2(LOG_N_MAX + 1)
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iSTART,
    input  logic [LN_BIT-1:0]    iLOG2_N,
    input  logic                 iBITREV,
    input  logic                 iHOLD,
    output logic [LOG_N_MAX-1:0] oADDR_RD_0,
    output logic [LOG_N_MAX-1:0] oADDR_RD_1,
    output logic [LOG_N_MAX-1:0] oADDR_WR_0,
    output logic [LOG_N_MAX-1:0] oADDR_WR_1,
    output logic [LOG_N_MAX-2:0] oADDR_COEF,
    output logic [LN_BIT-1:0]    oSTAGE,
    output logic                 oST_ZERO,
    output logic                 oST_LAST,
    output logic                 oRD_VALID,
    output logic                 oWE_A,
    output logic                 oWE_B,
    output logic                 oSOURCE_DATA,
    output logic                 oRDY,
    output logic                 oDONE
);

    localparam int AW = LOG_N_MAX;              // address width
    localparam int BW = LOG_N_MAX - 1;          // butterfly index width
    localparam int CW = $clog2(PIPE_LAT + 1);   // drain counter width
    localparam int PW = 2 + 2 * AW;             // pipeline entry: vld, parity, a0, a1

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [LN_BIT-1:0] l_q, l_d;
    logic              bitrev_q, bitrev_d;
    logic [LN_BIT-1:0] stage_q, stage_d;
    logic [BW-1:0]     b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;

    logic [LN_BIT-1:0] l_clamp;
    logic [BW-1:0]     last_b;
    logic [AW-1:0]     b_ext;
    logic [AW-1:0]     grp;
    logic [AW-1:0]     half_aw;
    logic [BW-1:0]     half_bw;
    logic [BW-1:0]     pos_bw;
    logic [AW-1:0]     a0;
    logic [AW-1:0]     a1;
    logic [AW-1:0]     a0_flip;
    logic [AW-1:0]     a1_flip;
    logic [AW-1:0]     a0_rev;
    logic [AW-1:0]     a1_rev;
    logic [BW-1:0]     coef;
    logic              rd_active;
    logic              rd_valid;
    logic [AW-1:0]     rd0_out;
    logic [AW-1:0]     rd1_out;

    logic [PW-1:0]     pipe_in;
    logic [PW-1:0]     pipe_q [PIPE_LAT];
    logic [PW-1:0]     pipe_out;

    // Clamp the requested size to the supported range [2, LOG_N_MAX].
    always_comb begin
        l_clamp = iLOG2_N;
        if (iLOG2_N < LN_BIT'(2)) begin
            l_clamp = LN_BIT'(2);
        end else if (iLOG2_N > LN_BIT'(LOG_N_MAX)) begin
            l_clamp = LN_BIT'(LOG_N_MAX);
        end
    end

    // Index of the last butterfly in a stage, N/2-1. For L=LOG_N_MAX the
    // shift overflows to zero and the subtraction wraps to all ones.
    assign last_b = (BW'(1) << (l_q - LN_BIT'(1))) - BW'(1);

    // Butterfly address arithmetic for the current (stage, butterfly).
    // half_bw overflows to zero when s = LOG_N_MAX-1, so the mask becomes
    // all ones, which is exactly right since b < 2^(LOG_N_MAX-1).
    always_comb begin
        b_ext   = {1'b0, b_q};
        grp     = b_ext >> stage_q;
        half_aw = AW'(1) << stage_q;
        half_bw = BW'(1) << stage_q;
        pos_bw  = b_q & (half_bw - BW'(1));
        a0      = (grp << (stage_q + LN_BIT'(1))) | {1'b0, pos_bw};
        a1      = a0 | half_aw;
        coef    = pos_bw << (l_q - stage_q - LN_BIT'(1));
    end

    // Full-width bit mirror; shifting right by (LOG_N_MAX-L) turns it into
    // a reversal over the low L bits, since bits above L-1 are always zero.
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_flip
            assign a0_flip[gi] = a0[AW-1-gi];
            assign a1_flip[gi] = a1[AW-1-gi];
        end
    endgenerate

    assign a0_rev = a0_flip >> (LN_BIT'(LOG_N_MAX) - l_q);
    assign a1_rev = a1_flip >> (LN_BIT'(LOG_N_MAX) - l_q);

    // Read-side outputs: live only in READ, bit-reversed on stage 0 when requested.
    always_comb begin
        rd_active = (state_q == ST_READ);
        rd_valid  = rd_active && !iHOLD;
        rd0_out   = '0;
        rd1_out   = '0;
        if (rd_active) begin
            if (bitrev_q && (stage_q == LN_BIT'(0))) begin
                rd0_out = a0_rev;
                rd1_out = a1_rev;
            end else begin
                rd0_out = a0;
                rd1_out = a1;
            end
        end
    end

    // State register and latched transform parameters.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q  <= ST_IDLE;
            l_q      <= LN_BIT'(2);
            bitrev_q <= 1'b0;
            stage_q  <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            l_q      <= l_d;
            bitrev_q <= bitrev_d;
            stage_q  <= stage_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: IDLE -> READ -> DRAIN -> (READ | IDLE).
    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        bitrev_d = bitrev_q;
        stage_d  = stage_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d  = ST_READ;
                    l_d      = l_clamp;
                    bitrev_d = iBITREV;
                    stage_d  = '0;
                    b_d      = '0;
                end
            end
            ST_READ: begin
                if (!iHOLD) begin
                    if (b_q == last_b) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                        b_d     = '0;
                    end else begin
                        b_d = b_q + BW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(PIPE_LAT - 1)) begin
                    if (stage_q == (l_q - LN_BIT'(1))) begin
                        state_d = ST_IDLE;
                        stage_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        stage_d = stage_q + LN_BIT'(1);
                        b_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pipe_in = {rd_valid, stage_q[0], rd0_out, rd1_out};

    // Delay line modelling the butterfly datapath latency; cleared on reset
    // so no stale writes surface afterwards.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign pipe_out = pipe_q[PIPE_LAT-1];

    assign oADDR_RD_0   = rd0_out;
    assign oADDR_RD_1   = rd1_out;
    assign oADDR_COEF   = rd_active ? coef : '0;
    assign oRD_VALID    = rd_valid;
    assign oADDR_WR_0   = pipe_out[2*AW-1:AW];
    assign oADDR_WR_1   = pipe_out[AW-1:0];
    // Even stages read A and write B; odd stages read B and write A.
    assign oWE_B        = pipe_out[PW-1] & ~pipe_out[PW-2];
    assign oWE_A        = pipe_out[PW-1] &  pipe_out[PW-2];
    assign oSOURCE_DATA = stage_q[0];
    assign oSTAGE       = stage_q;
    assign oST_ZERO     = (stage_q == LN_BIT'(0));
    assign oST_LAST     = (stage_q == (l_q - LN_BIT'(1)));
    assign oRDY         = (state_q == ST_IDLE);
    assign oDONE        = done_q;

endmodule

// File: tb/tb_fht_addr_sched.sv
// Directed testbench for fht_addr_sched (LOG_N_MAX=10, PIPE_LAT=4).
module tb_fht_addr_sched;

    localparam int LOG_N_MAX = 10;
    localparam int PIPE_LAT  = 4;
    localparam int LN_BIT    = 4;

    logic                 clk = 1'b0;
    logic                 iRESET, iSTART, iBITREV, iHOLD;
    logic [LN_BIT-1:0]    iLOG2_N;
    logic [LOG_N_MAX-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_WR_0, oADDR_WR_1;
    logic [LOG_N_MAX-2:0] oADDR_COEF;
    logic [LN_BIT-1:0]    oSTAGE;
    logic                 oST_ZERO, oST_LAST, oRD_VALID, oWE_A, oWE_B;
    logic                 oSOURCE_DATA, oRDY, oDONE;

    int tests = 0;
    int fails = 0;

    // Hand-computed L=3 read schedule, index k = stage*4 + butterfly.
    int rd0_tab [12];
    int rd1_tab [12];
    int coef_tab[12];
    int br0_tab [4];
    int br1_tab [4];

    always #5 clk = ~clk;

    fht_addr_sched #(.LOG_N_MAX(LOG_N_MAX), .PIPE_LAT(PIPE_LAT)) dut (
        .iCLK(clk), .iRESET(iRESET), .iSTART(iSTART), .iLOG2_N(iLOG2_N),
        .iBITREV(iBITREV), .iHOLD(iHOLD),
        .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1),
        .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
        .oADDR_COEF(oADDR_COEF), .oSTAGE(oSTAGE),
        .oST_ZERO(oST_ZERO), .oST_LAST(oST_LAST), .oRD_VALID(oRD_VALID),
        .oWE_A(oWE_A), .oWE_B(oWE_B), .oSOURCE_DATA(oSOURCE_DATA),
        .oRDY(oRDY), .oDONE(oDONE)
    );

    task automatic do_start(input int l, input bit br);
        @(posedge clk); #1;
        iLOG2_N = LN_BIT'(l);
        iBITREV = br;
        iHOLD   = 1'b0;
        iSTART  = 1'b1;
        @(posedge clk); #1;
        iSTART  = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        iRESET = 1'b1; iSTART = 1'b1; iHOLD = 1'b0; iBITREV = 1'b0; iLOG2_N = 4'd3;
        @(posedge clk); @(posedge clk); #1;
        iRESET = 1'b0; iSTART = 1'b0;
        #1;
        obs = {oRDY, oRD_VALID, oWE_A, oWE_B, oDONE, oSOURCE_DATA, oSTAGE, 2'b00};
        tests++;
        if (obs !== 12'b1000_0000_0000) begin
            fails++;
            $display("FAIL reset_flags got=%b want=%b", obs, 12'b1000_0000_0000);
        end
        tests++;
        if ({oADDR_RD_0, oADDR_RD_1, oADDR_WR_0, oADDR_WR_1, oADDR_COEF} !== 49'd0) begin
            fails++;
            $display("FAIL reset_addr got rd=%0d/%0d wr=%0d/%0d coef=%0d want all 0",
                     oADDR_RD_0, oADDR_RD_1, oADDR_WR_0, oADDR_WR_1, oADDR_COEF);
        end
        $display("[TB] test_reset done");
    endtask

    // Full L=3 transform with optional bit-reverse and a 2-cycle hold in stage 1.
    task automatic test_l3(input bit br, input bit hold, input string name);
        bit   ev[64];
        int   e0[64];
        int   e1[64];
        bit   ep[64];
        int   k = 0;
        int   busy = 0;
        int   s;
        bit   finished = 0;
        logic [9:0] x0, x1;
        logic [8:0] xc;
        logic [1:0] we_exp;
        for (int i = 0; i < 64; i++) begin ev[i] = 0; e0[i] = 0; e1[i] = 0; ep[i] = 0; end
        do_start(3, br);
        for (int c = 0; c < 60 && !finished; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            iHOLD = hold && (c == 9 || c == 10);
            #1;
            if (oRDY) begin
                finished = 1;
                tests++;
                if (oDONE !== 1'b1) begin
                    fails++;
                    $display("FAIL %s done_first_idle got=%b want=1", name, oDONE);
                end
            end else begin
                busy++;
                if (oDONE !== 1'b0) begin
                    tests++; fails++;
                    $display("FAIL %s done_while_busy c=%0d got=1 want=0", name, c);
                end
                if (k < 12) begin
                    s  = k / 4;
                    x0 = (br && s == 0) ? 10'(br0_tab[k]) : 10'(rd0_tab[k]);
                    x1 = (br && s == 0) ? 10'(br1_tab[k]) : 10'(rd1_tab[k]);
                    xc = 9'(coef_tab[k]);
                end
                if (oRD_VALID) begin
                    tests++;
                    if (k >= 12) begin
                        fails++;
                        $display("FAIL %s extra_read c=%0d got=%0d want<=12", name, c, k + 1);
                    end else begin
                        if ({oADDR_RD_0, oADDR_RD_1, oADDR_COEF} !== {x0, x1, xc} ||
                            oSTAGE !== 4'(s) || oST_ZERO !== (s == 0) ||
                            oST_LAST !== (s == 2) || oSOURCE_DATA !== s[0]) begin
                            fails++;
                            $display("FAIL %s read k=%0d got=(%0d,%0d) coef=%0d st=%0d z=%b l=%b src=%b want=(%0d,%0d) coef=%0d st=%0d",
                                     name, k, oADDR_RD_0, oADDR_RD_1, oADDR_COEF, oSTAGE,
                                     oST_ZERO, oST_LAST, oSOURCE_DATA, x0, x1, xc, s);
                        end
                        $display("[TB] %s read k=%0d s=%0d (%0d,%0d) coef=%0d", name, k, s,
                                 oADDR_RD_0, oADDR_RD_1, oADDR_COEF);
                        ev[c] = 1; e0[c] = int'(x0); e1[c] = int'(x1); ep[c] = s[0];
                        k++;
                    end
                end else if (iHOLD) begin
                    tests++;
                    if ({oADDR_RD_0, oADDR_RD_1} !== {x0, x1}) begin
                        fails++;
                        $display("FAIL %s hold_addr c=%0d got=(%0d,%0d) want=(%0d,%0d)",
                                 name, c, oADDR_RD_0, oADDR_RD_1, x0, x1);
                    end
                end
            end
            // Write side: mirrors the expected read issued PIPE_LAT cycles ago.
            if (c >= PIPE_LAT) begin
                we_exp = ev[c-PIPE_LAT] ? (ep[c-PIPE_LAT] ? 2'b10 : 2'b01) : 2'b00;
                tests++;
                if ({oWE_A, oWE_B} !== we_exp) begin
                    fails++;
                    $display("FAIL %s we c=%0d got=%b%b want=%b", name, c, oWE_A, oWE_B, we_exp);
                end
                if (ev[c-PIPE_LAT]) begin
                    tests++;
                    if ({oADDR_WR_0, oADDR_WR_1} !== {10'(e0[c-PIPE_LAT]), 10'(e1[c-PIPE_LAT])}) begin
                        fails++;
                        $display("FAIL %s wr_addr c=%0d got=(%0d,%0d) want=(%0d,%0d)", name, c,
                                 oADDR_WR_0, oADDR_WR_1, e0[c-PIPE_LAT], e1[c-PIPE_LAT]);
                    end
                end
            end
        end
        iHOLD = 1'b0;
        tests++;
        if (!finished || busy != (hold ? 26 : 24) || k != 12) begin
            fails++;
            $display("FAIL %s busy_reads finished=%b busy=%0d reads=%0d want busy=%0d reads=12",
                     name, finished, busy, k, hold ? 26 : 24);
        end
        @(posedge clk); #2;
        tests++;
        if ({oDONE, oRDY} !== 2'b01) begin
            fails++;
            $display("FAIL %s done_pulse_width got done=%b rdy=%b want done=0 rdy=1", name, oDONE, oRDY);
        end
        $display("[TB] %s busy=%0d reads=%0d", name, busy, k);
    endtask

    // Size clamping and start-while-busy; counts busy cycles, reads and writes.
    task automatic test_busy(input int lin, input int exp_l, input int exp_busy,
                             input bit repulse, input string name);
        int busy = 0, reads = 0, writes = 0, both = 0, max_st = 0;
        bit finished = 0;
        do_start(lin, 0);
        for (int c = 0; c < 6000 && !finished; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            iSTART  = repulse && (c == 5);
            if (repulse && c == 5) iLOG2_N = 4'd3;
            #1;
            if (oRDY) begin
                finished = 1;
                tests++;
                if (oDONE !== 1'b1) begin
                    fails++;
                    $display("FAIL %s done_first_idle got=%b want=1", name, oDONE);
                end
            end else begin
                busy++;
            end
            if (oRD_VALID) reads++;
            if (oWE_A || oWE_B) writes++;
            if (oWE_A && oWE_B) both++;
            if (int'(oSTAGE) > max_st) max_st = int'(oSTAGE);
        end
        iSTART = 1'b0;
        tests++;
        if (!finished || busy != exp_busy) begin
            fails++;
            $display("FAIL %s busy got=%0d finished=%b want=%0d", name, busy, finished, exp_busy);
        end
        tests++;
        if (reads != exp_l * (1 << (exp_l - 1)) || writes != reads || both != 0 || max_st != exp_l - 1) begin
            fails++;
            $display("FAIL %s counts got reads=%0d writes=%0d both=%0d maxst=%0d want reads=%0d maxst=%0d",
                     name, reads, writes, both, max_st, exp_l * (1 << (exp_l - 1)), exp_l - 1);
        end
        $display("[TB] %s busy=%0d reads=%0d writes=%0d", name, busy, reads, writes);
    endtask

    // Reset in the middle of stage 1 must abandon the run cleanly.
    task automatic test_reset_mid();
        int stray = 0;
        do_start(3, 0);
        for (int c = 1; c <= 9; c++) begin @(posedge clk); #1; end
        #1;
        tests++;
        if ({oRD_VALID, oSTAGE} !== {1'b1, 4'd1}) begin
            fails++;
            $display("FAIL reset_mid_pre got vld=%b st=%0d want vld=1 st=1", oRD_VALID, oSTAGE);
        end
        iRESET = 1'b1;
        @(posedge clk); #1;
        iRESET = 1'b0;
        #1;
        tests++;
        if ({oRDY, oRD_VALID, oSTAGE, oDONE} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_state got rdy=%b vld=%b st=%0d done=%b want 1,0,0,0",
                     oRDY, oRD_VALID, oSTAGE, oDONE);
        end
        for (int c = 0; c < 10; c++) begin
            if (oWE_A || oWE_B || oDONE || !oRDY) stray++;
            @(posedge clk); #2;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL reset_mid_stray got=%0d cycles with we/done/busy want=0", stray);
        end
        $display("[TB] test_reset_mid stray=%0d", stray);
    endtask

    initial begin
        rd0_tab  = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
        rd1_tab  = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
        coef_tab = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
        br0_tab  = '{0, 2, 1, 3};
        br1_tab  = '{4, 6, 5, 7};
        iRESET = 1'b1; iSTART = 1'b0; iHOLD = 1'b0; iBITREV = 1'b0; iLOG2_N = '0;

        test_reset();
        test_l3(1'b0, 1'b0, "l3_plain");
        test_l3(1'b1, 1'b0, "l3_bitrev");
        test_l3(1'b0, 1'b1, "l3_hold");
        test_busy(1, 2, 12, 1'b1, "clamp_lo_repulse");
        test_busy(15, 10, 5160, 1'b0, "clamp_hi");
        test_reset_mid();
        test_l3(1'b0, 1'b0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
